// File: rtl/alu_decoder_pipe.sv
// Execute-stage ALU decoder for the ARM data-processing set, followed by a
// STAGES-deep valid/stall/flush output pipeline and a saturating illegal-decode counter.
module alu_decoder_pipe #(
    parameter int ALU_CTRL_W = 3,
    parameter int STAGES     = 1,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_in,
    input  logic                  ALUOp,
    input  logic [4:0]            Funct,
    input  logic                  stall,
    input  logic                  flush,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [1:0]            FlagW,
    output logic                  NoWrite,
    output logic                  Illegal,
    output logic                  valid_out,
    output logic [CNT_W-1:0]      illegal_cnt
);

    // Handshake: valid_in marks a decode request; it is consumed on a rising edge
    // only when stall=0 and flush=0. valid_out marks the final stage; while stall=1
    // it is held, and flush clears every stage (flush wins over stall).

    localparam int PW = ALU_CTRL_W + 4;

    logic [3:0]            cmd;
    logic                  s_bit;
    logic [2:0]            dec_code;
    logic                  dec_cv;
    logic                  dec_cmp;
    logic                  dec_bad;
    logic [ALU_CTRL_W-1:0] dec_ctrl;
    logic [1:0]            dec_flagw;
    logic                  dec_nowrite;
    logic                  dec_illegal;
    logic [PW-1:0]         dec_pay;

    always_comb begin
        cmd         = Funct[4:1];
        s_bit       = Funct[0];
        dec_code    = 3'b000;
        dec_cv      = 1'b0;
        dec_cmp     = 1'b0;
        dec_bad     = 1'b0;
        dec_ctrl    = '0;
        dec_flagw   = 2'b00;
        dec_nowrite = 1'b0;
        dec_illegal = 1'b0;
        if (ALUOp) begin
            case (cmd)
                4'b0100: begin dec_code = 3'b000; dec_cv = 1'b1; end
                4'b0010: begin dec_code = 3'b001; dec_cv = 1'b1; end
                4'b0000: dec_code = 3'b010;
                4'b1100: dec_code = 3'b011;
                4'b0001: dec_code = 3'b100;
                4'b0011: begin dec_code = 3'b101; dec_cv = 1'b1; end
                4'b1110: dec_code = 3'b110;
                4'b1101: dec_code = 3'b111;
                4'b1010: begin dec_code = 3'b001; dec_cv = 1'b1; dec_cmp = 1'b1; end
                4'b1011: begin dec_code = 3'b000; dec_cv = 1'b1; dec_cmp = 1'b1; end
                4'b1000: begin dec_code = 3'b010; dec_cmp = 1'b1; end
                4'b1001: begin dec_code = 3'b100; dec_cmp = 1'b1; end
                default: dec_bad = 1'b1;
            endcase
            // Compare forms exist only to set flags, so S=0 on them is meaningless.
            if (dec_cmp && !s_bit) begin
                dec_bad = 1'b1;
            end
            if (ALU_CTRL_W == 2 && dec_code[2]) begin
                dec_bad = 1'b1;
            end
            if (dec_bad) begin
                dec_nowrite = 1'b1;
                dec_illegal = 1'b1;
            end else begin
                dec_ctrl    = dec_code[ALU_CTRL_W-1:0];
                dec_flagw   = {s_bit, s_bit & dec_cv};
                dec_nowrite = dec_cmp;
            end
        end
        dec_pay = {dec_ctrl, dec_flagw, dec_nowrite, dec_illegal};
    end

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [PW-1:0]     pay_q [STAGES];
    logic [PW-1:0]     pay_d [STAGES];
    logic [CNT_W-1:0]  illegal_cnt_q;
    logic [CNT_W-1:0]  illegal_cnt_d;
    logic              take_in;

    always_comb begin
        take_in       = valid_in && !stall && !flush;
        vld_d         = vld_q;
        pay_d         = pay_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            vld_d = '0;
        end else if (!stall) begin
            vld_d[0] = valid_in;
            pay_d[0] = dec_pay;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                pay_d[i] = pay_q[i-1];
            end
        end
        if (take_in && dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q         <= '0;
            illegal_cnt_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            vld_q         <= vld_d;
            illegal_cnt_q <= illegal_cnt_d;
            for (int i = 0; i < STAGES; i++) begin
                pay_q[i] <= pay_d[i];
            end
        end
    end

    // Payload of an invalid final stage is masked so idle outputs read zero.
    logic [PW-1:0] out_pay;

    always_comb begin
        out_pay = pay_q[STAGES-1] & {PW{vld_q[STAGES-1]}};
    end

    assign {ALUControl, FlagW, NoWrite, Illegal} = out_pay;
    assign valid_out   = vld_q[STAGES-1];
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_decoder_pipe.sv
// Scoreboard bench for alu_decoder_pipe: three configurations share one stimulus stream,
// each with a table-driven reference model, expected queue and negedge monitor.
module tb_alu_decoder_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid_in;
    logic       alu_op;
    logic [4:0] funct;
    logic       stall;
    logic       flush;
    logic       armed = 1'b0;

    int checks   = 0;
    int failures = 0;

    // ALU code per cmd (-1 = undefined cmd) and which ops write C/V.
    int code_tab [16] = '{2, 4, 1, 5, 0, -1, -1, -1, 2, 4, 1, 0, 3, 7, 6, -1};
    bit cv_tab   [16] = '{0, 0, 1, 1, 1,  0,  0,  0, 0, 0, 1, 1, 0, 0, 0,  0};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ctrl[2:0], flagw[1:0], nowrite, illegal}.
    function automatic logic [6:0] ref_decode(input logic aluop, input logic [4:0] f, input int w);
        int  c;
        int  code;
        bit  s;
        bit  is_cmp;
        bit  bad;
        logic [2:0] code3;
        c      = int'(f[4:1]);
        s      = f[0];
        code   = code_tab[c];
        is_cmp = (c >= 8) && (c <= 11);
        bad    = (code < 0) || (is_cmp && !s) || (w == 2 && code >= 4);
        if (!aluop) return 7'd0;
        if (bad) return 7'b000_00_1_1;
        code3 = 3'(code);
        return {code3, s, s & cv_tab[c], is_cmp, 1'b0};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int W = (gi == 1) ? 2 : 3;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
        localparam int C = (gi == 0) ? 8 : 2;

        logic [W-1:0] ctrl_o;
        logic [1:0]   flagw_o;
        logic         nowrite_o;
        logic         illegal_o;
        logic         valid_o;
        logic [C-1:0] cnt_o;

        alu_decoder_pipe #(.ALU_CTRL_W(W), .STAGES(S), .CNT_W(C)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .valid_in   (valid_in),
            .ALUOp      (alu_op),
            .Funct      (funct),
            .stall      (stall),
            .flush      (flush),
            .ALUControl (ctrl_o),
            .FlagW      (flagw_o),
            .NoWrite    (nowrite_o),
            .Illegal    (illegal_o),
            .valid_out  (valid_o),
            .illegal_cnt(cnt_o)
        );

        logic [6:0] exp_q [$];
        int         due_q [$];
        int         adv        = 0;
        int         mcnt       = 0;
        bit         last_stall = 0;
        logic [7:0] prev       = '0;
        logic [7:0] cur;
        logic [6:0] p;

        always_comb cur = {valid_o, 3'(ctrl_o), flagw_o, nowrite_o, illegal_o};

        // Reference model: advances on every edge the pipeline moves.
        initial begin
            forever begin
                @(posedge clk or negedge reset_n);
                if (!reset_n) begin
                    exp_q.delete();
                    due_q.delete();
                    adv        = 0;
                    mcnt       = 0;
                    last_stall = 0;
                end else if (flush) begin
                    exp_q.delete();
                    due_q.delete();
                    adv++;
                    last_stall = 0;
                end else if (stall) begin
                    last_stall = 1;
                end else begin
                    adv++;
                    last_stall = 0;
                    if (valid_in) begin
                        p = ref_decode(alu_op, funct, W);
                        exp_q.push_back(p);
                        due_q.push_back(adv + S - 1);
                        if (p[0] && mcnt < (2 ** C) - 1) mcnt++;
                    end
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                if (!reset_n) begin
                    chk($sformatf("cfg%0d reset_out", gi), 32'(cur), 32'd0);
                end else if (last_stall) begin
                    chk($sformatf("cfg%0d stall_hold", gi), 32'(cur), 32'(prev));
                end else if (due_q.size() > 0 && due_q[0] == adv) begin
                    chk($sformatf("cfg%0d result", gi), 32'(cur), 32'({1'b1, exp_q[0]}));
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                end else begin
                    chk($sformatf("cfg%0d idle_zero", gi), 32'(cur), 32'd0);
                end
                chk($sformatf("cfg%0d illegal_cnt", gi), 32'(cnt_o), 32'(mcnt));
                prev = cur;
            end
        end

        // Asynchronous reset must clear outputs before any clock edge.
        initial begin
            forever begin
                @(negedge reset_n);
                #1;
                if (armed) begin
                    chk($sformatf("cfg%0d async_reset_out", gi), 32'(cur), 32'd0);
                    chk($sformatf("cfg%0d async_reset_cnt", gi), 32'(cnt_o), 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic op, input logic [4:0] f,
                         input logic st, input logic fl);
        @(posedge clk);
        #1;
        valid_in = v;
        alu_op   = op;
        funct    = f;
        stall    = st;
        flush    = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 19) == 0));
        end
    endtask

    logic [4:0] dir_f [6] = '{5'b01001, 5'b10101, 5'b10001, 5'b10100, 5'b00010, 5'b11011};

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        alu_op   = 1'b0;
        funct    = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        armed = 1'b1;
        idle(2);

        // Directed decodes: ADD,S / CMP,S / TST,S / CMP S=0 / EOR / MOV,S
        foreach (dir_f[i]) begin
            drive(1'b1, 1'b1, dir_f[i], 1'b0, 1'b0);
            idle(1);
        end
        drive(1'b1, 1'b0, 5'b10100, 1'b0, 1'b0);
        idle(5);

        // A, B, then two stall cycles, then C
        drive(1'b1, 1'b1, 5'b01001, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'b00101, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'b11000, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 5'b11000, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 5'b11000, 1'b0, 1'b0);
        idle(6);

        // Two in flight, flush with stall and valid_in, then one more op
        drive(1'b1, 1'b1, 5'b01000, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'b10100, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 5'b10100, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 5'b00111, 1'b0, 1'b0);
        idle(6);

        // Illegal burst to drive the small counters into saturation
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 5'b01010, 1'b0, 1'b0);
        idle(5);

        rand_cycles(400);

        // Reset mid-stream, away from any clock edge
        rand_cycles(5);
        @(posedge clk);
        #3 reset_n = 1'b0;
        valid_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rand_cycles(60);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
